// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit counter encoding,
// reset value, saturating step function and BTB entry flags.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CtrSnt   = 2'b00;
    localparam ctr_t CtrWnt   = 2'b01;
    localparam ctr_t CtrWt    = 2'b10;
    localparam ctr_t CtrSt    = 2'b11;
    localparam ctr_t CtrReset = CtrWnt;

    typedef struct packed {
        logic valid;
        logic is_jump;
    } btb_flags_t;

    function automatic ctr_t ctr_step(input ctr_t ctr, input logic taken);
        ctr_t res;
        res = ctr;
        if (taken) begin
            if (ctr != CtrSt) res = ctr + 2'b01;
        end else begin
            if (ctr != CtrSnt) res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Branch target buffer: direct-mapped array of {valid, is_jump, tag, target}
// with one combinational read port and one synchronous write port.
module bp_btb
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [TAG_W-1:0] rd_tag_i,
    output logic             hit_o,
    output logic             is_jump_o,
    output logic [XLEN-1:0]  target_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             wr_is_jump_i,
    input  logic [XLEN-1:0]  wr_target_i
);

    localparam int unsigned Entries = 2 ** IDX_W;

    btb_flags_t       flags_q  [Entries];
    logic [TAG_W-1:0] tag_q    [Entries];
    logic [XLEN-1:0]  target_q [Entries];

    always_comb begin
        hit_o     = flags_q[rd_idx_i].valid && (tag_q[rd_idx_i] == rd_tag_i);
        is_jump_o = flags_q[rd_idx_i].is_jump;
        target_o  = target_q[rd_idx_i];
    end

    // Only the valid bits need clearing; tag and target are qualified by valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(Entries); i++) begin
                flags_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            flags_q[wr_idx_i]  <= '{valid: 1'b1, is_jump: wr_is_jump_i};
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 2-bit BHT plus BTB lookup, resolve-side update and
// mispredict/redirect generation. Define BP_GSHARE_EN to hash a global history into the BHT index.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             prediction,
    output logic [XLEN-1:0]  pred_target,
    output logic [IDX_W-1:0] pred_hist,
    input  logic             upd_valid,
    input  logic             upd_is_jump,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred,
    input  logic [XLEN-1:0]  upd_pred_target,
    input  logic [IDX_W-1:0] upd_hist,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc
);

    localparam int unsigned Entries = 2 ** IDX_W;

    ctr_t             bht_q [Entries];
    logic [IDX_W-1:0] lk_bht_idx;
    logic [IDX_W-1:0] upd_bht_idx;
    logic             btb_hit;
    logic             btb_is_jump;
    logic [XLEN-1:0]  btb_target;
    logic             upd_en;

    assign upd_en = upd_valid && !rst;

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;

    // History advances only on resolved conditional branches, never speculatively.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (upd_valid && !upd_is_jump) begin
            ghr_q <= {ghr_q[IDX_W-2:0], upd_taken};
        end
    end

    assign pred_hist   = ghr_q;
    assign lk_bht_idx  = fetch_pc[IDX_W+1:2] ^ ghr_q;
    assign upd_bht_idx = upd_pc[IDX_W+1:2] ^ upd_hist;
`else
    logic unused_hist;
    assign unused_hist = ^upd_hist;
    assign pred_hist   = '0;
    assign lk_bht_idx  = fetch_pc[IDX_W+1:2];
    assign upd_bht_idx = upd_pc[IDX_W+1:2];
`endif

    bp_btb #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W),
        .XLEN  (XLEN)
    ) u_btb (
        .clk          (clk),
        .rst          (rst),
        .rd_idx_i     (fetch_pc[IDX_W+1:2]),
        .rd_tag_i     (fetch_pc[IDX_W+TAG_W+1:IDX_W+2]),
        .hit_o        (btb_hit),
        .is_jump_o    (btb_is_jump),
        .target_o     (btb_target),
        .wr_en_i      (upd_en && upd_taken),
        .wr_idx_i     (upd_pc[IDX_W+1:2]),
        .wr_tag_i     (upd_pc[IDX_W+TAG_W+1:IDX_W+2]),
        .wr_is_jump_i (upd_is_jump),
        .wr_target_i  (upd_target)
    );

    always_comb begin
        prediction  = btb_hit && (btb_is_jump || bht_q[lk_bht_idx][1]);
        pred_target = prediction ? btb_target : fetch_pc + XLEN'(4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(Entries); i++) begin
                bht_q[i] <= CtrReset;
            end
        end else if (upd_valid) begin
            bht_q[upd_bht_idx] <= upd_is_jump ? CtrSt : ctr_step(bht_q[upd_bht_idx], upd_taken);
        end
    end

    always_comb begin
        mispredict  = upd_en && ((upd_pred != upd_taken) ||
                                 (upd_pred && upd_taken && (upd_pred_target != upd_target)));
        redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a driver pushes expectations from an
// array-based reference model, a negedge monitor pops and compares.
module tb_branch_predictor;

    localparam int IDX_W = 6;
    localparam int TAG_W = 8;
    localparam int XLEN  = 32;
    localparam int N     = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             rst;
    logic [XLEN-1:0]  fetch_pc;
    logic             prediction;
    logic [XLEN-1:0]  pred_target;
    logic [IDX_W-1:0] pred_hist;
    logic             upd_valid;
    logic             upd_is_jump;
    logic [XLEN-1:0]  upd_pc;
    logic             upd_taken;
    logic [XLEN-1:0]  upd_target;
    logic             upd_pred;
    logic [XLEN-1:0]  upd_pred_target;
    logic [IDX_W-1:0] upd_hist;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;

    always #5 clk = ~clk;

    branch_predictor #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W),
        .XLEN  (XLEN)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_pc        (fetch_pc),
        .prediction      (prediction),
        .pred_target     (pred_target),
        .pred_hist       (pred_hist),
        .upd_valid       (upd_valid),
        .upd_is_jump     (upd_is_jump),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred        (upd_pred),
        .upd_pred_target (upd_pred_target),
        .upd_hist        (upd_hist),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc)
    );

    typedef struct {
        string       name;
        bit          pred;
        bit [31:0]   target;
        bit [5:0]    hist;
        bit          misp;
        bit [31:0]   redir;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: counters as plain integers 0..3
    int        m_cnt   [N];
    bit        m_valid [N];
    bit        m_jump  [N];
    int        m_tag   [N];
    bit [31:0] m_tgt   [N];
    bit [5:0]  m_ghr;

    function automatic int pc_idx(input bit [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic int pc_tag(input bit [31:0] pc);
        return int'((pc >> (IDX_W + 2)) % (1 << TAG_W));
    endfunction

    function automatic int bht_index(input bit [31:0] pc, input bit [5:0] h);
`ifdef BP_GSHARE_EN
        return pc_idx(pc) ^ int'(h);
`else
        return pc_idx(pc) + 0 * int'(h);
`endif
    endfunction

    function automatic bit model_pred(input bit [31:0] pc);
        int  t;
        bit  hit;
        t   = pc_idx(pc);
        hit = m_valid[t] && (m_tag[t] == pc_tag(pc));
        return hit && (m_jump[t] || m_cnt[bht_index(pc, m_ghr)] >= 2);
    endfunction

    function automatic bit [5:0] model_hist();
`ifdef BP_GSHARE_EN
        return m_ghr;
`else
        return 6'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i]   = 1;
            m_valid[i] = 1'b0;
            m_jump[i]  = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 32'd0;
        end
        m_ghr = 6'd0;
    endtask

    // Apply one cycle of stimulus, push expected outputs, then advance the model.
    task automatic step(input string nm, input bit r, input bit [31:0] fpc, input bit uv,
                        input bit uj, input bit [31:0] upc, input bit ut, input bit [31:0] utgt,
                        input bit up, input bit [31:0] uptgt, input bit [5:0] uh);
        exp_t e;
        int   b;
        int   t;
        @(posedge clk);
        #1;
        rst = r; fetch_pc = fpc; upd_valid = uv; upd_is_jump = uj; upd_pc = upc;
        upd_taken = ut; upd_target = utgt; upd_pred = up; upd_pred_target = uptgt;
        upd_hist = uh;
        e.name   = nm;
        e.pred   = model_pred(fpc);
        t        = pc_idx(fpc);
        e.target = e.pred ? m_tgt[t] : fpc + 32'd4;
        e.hist   = model_hist();
        e.misp   = uv && !r && ((up != ut) || (up && ut && uptgt != utgt));
        e.redir  = ut ? utgt : upc + 32'd4;
        exp_q.push_back(e);
        if (r) begin
            model_reset();
        end else if (uv) begin
            b = bht_index(upc, uh);
            if (uj) m_cnt[b] = 3;
            else if (ut) m_cnt[b] = (m_cnt[b] == 3) ? 3 : m_cnt[b] + 1;
            else m_cnt[b] = (m_cnt[b] == 0) ? 0 : m_cnt[b] - 1;
            if (ut) begin
                t          = pc_idx(upc);
                m_valid[t] = 1'b1;
                m_jump[t]  = uj;
                m_tag[t]   = pc_tag(upc);
                m_tgt[t]   = utgt;
            end
            if (!uj) m_ghr = {m_ghr[4:0], ut};
        end
    endtask

    task automatic lookup(input string nm, input bit [31:0] fpc);
        step(nm, 1'b0, fpc, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, model_hist());
    endtask

    task automatic check(input string nm, input bit [31:0] act, input bit [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: outputs are combinational, so every driven cycle presents a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".prediction"}, {31'd0, prediction}, {31'd0, e.pred});
                check({e.name, ".pred_target"}, pred_target, e.target);
                check({e.name, ".pred_hist"}, {26'd0, pred_hist}, {26'd0, e.hist});
                check({e.name, ".mispredict"}, {31'd0, mispredict}, {31'd0, e.misp});
                check({e.name, ".redirect_pc"}, redirect_pc, e.redir);
            end
        end
    end

    initial begin
        bit [31:0] fpc, upc, utgt, uptgt;
        bit        uj, ut, up;
        bit [5:0]  uh;
        int        guard;

        rst = 1'b1; fetch_pc = '0; upd_valid = 1'b0; upd_is_jump = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; upd_pred = 1'b0; upd_pred_target = '0; upd_hist = '0;
        model_reset();
        repeat (2) @(posedge clk);

        step("reset", 1'b1, 32'h100, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 6'd0);
        lookup("reset_lookup", 32'h100);
        step("train", 1'b0, 32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104,
             model_hist());
        lookup("trained_lookup", 32'h100);
        for (int i = 0; i < 5; i++) begin
            step("sat_update", 1'b0, 32'h100, 1'b1, 1'b0, 32'h100, 1'b0, 32'h80,
                 model_pred(32'h100), 32'h80, model_hist());
        end
        lookup("sat_lookup", 32'h100);
        step("jump", 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h40, 1'b0, 32'h204,
             model_hist());
        lookup("jump_lookup", 32'h200);
        step("misp_target", 1'b0, 32'h300, 1'b1, 1'b0, 32'h340, 1'b1, 32'h90, 1'b1, 32'h80,
             model_hist());
        step("misp_not_taken", 1'b0, 32'h300, 1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b1,
             32'h80, model_hist());
        step("rst_priority", 1'b1, 32'h200, 1'b1, 1'b0, 32'h400, 1'b1, 32'h44, 1'b0,
             32'h404, model_hist());
        lookup("post_rst_jump", 32'h200);
        lookup("post_rst_upd", 32'h400);

        for (int i = 0; i < 1500; i++) begin
            upc   = ($urandom_range(0, 2) << (IDX_W + 2)) | ($urandom_range(0, 15) << 2);
            fpc   = ($urandom_range(0, 3) == 0) ? upc :
                    (($urandom_range(0, 2) << (IDX_W + 2)) | ($urandom_range(0, 15) << 2));
            uj    = ($urandom_range(0, 7) == 0);
            ut    = uj ? 1'b1 : 1'($urandom_range(0, 1));
            utgt  = $urandom & 32'hffff_fffc;
            up    = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : model_pred(upc);
            uptgt = ($urandom_range(0, 3) == 0) ? utgt : ($urandom & 32'hffff_fffc);
            uh    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : model_hist();
            step("random", ($urandom_range(0, 199) == 0), fpc, 1'($urandom_range(0, 2) != 0),
                 uj, upc, ut, utgt, up, uptgt, uh);
        end

        @(posedge clk);
        #1 upd_valid = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d pending expectations, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
